// File: rtl/dm_pkg.sv
// Shared definitions for the sub-word data memory: operation encoding,
// access-FSM states and a store classifier.
package dm_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/dm_lane_ctrl.sv
// Byte-lane steering for the data memory: store byte enables and replication,
// load lane selection with sign/zero extension, and alignment checking.
module dm_lane_ctrl
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    be       = 4'b0000;
    wword    = wdata;
    ldata    = raw;
    misalign = 1'b0;

    half_sel = lane[1] ? raw[31:16] : raw[15:0];
    case (lane)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase

    case (op)
      OP_LW:  misalign = (lane != 2'd0);
      OP_LH: begin
        ldata    = {{16{half_sel[15]}}, half_sel};
        misalign = lane[0];
      end
      OP_LHU: begin
        ldata    = {16'h0000, half_sel};
        misalign = lane[0];
      end
      OP_LB:  ldata = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: ldata = {24'h000000, byte_sel};
      OP_SW: begin
        be       = 4'b1111;
        misalign = (lane != 2'd0);
      end
      OP_SH: begin
        be       = 4'b0011 << lane;
        wword    = {2{wdata[15:0]}};
        misalign = lane[0];
      end
      OP_SB: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_subword.sv
// MEM-stage data memory with byte/halfword access, address error detection
// and an optional wait-state handshake for exercising pipeline stalls.
module dm_subword
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          LOG_WRITES  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_err
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             in_range;
  logic [31:0]      raw;
  logic [3:0]       be;
  logic [31:0]      wword;
  logic [31:0]      ldata;
  logic [31:0]      merged;
  logic             misalign;
  logic             err;
  logic             rdy;
  logic             we;

  assign off      = addr - BASE_ADDR;
  assign idx      = off[IDX_W+1:2];
  assign lane     = off[1:0];
  assign in_range = ({1'b0, off} < LIMIT);
  // Out-of-range addresses never index the array, keeping rdata free of X.
  assign raw      = in_range ? mem_q[idx] : 32'h0;

  dm_lane_ctrl u_lane_ctrl (
    .op       (op),
    .lane     (lane),
    .wdata    (wdata),
    .raw      (raw),
    .be       (be),
    .wword    (wword),
    .ldata    (ldata),
    .misalign (misalign)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wword[8*i +: 8] : raw[8*i +: 8];
    end
  end

  assign err = en & (~in_range | misalign);
  assign we  = en & rdy & ~err & is_store(op) & ~reset;

  // NOTE: the whole array is cleared on reset because loads after reset must
  // return 0, not power-up garbage; this rules out a plain block-RAM mapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      mem_q[idx] <= merged;
    end
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_comb
      assign rdy = en;
    end else begin : g_fsm
      localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             ready_q, ready_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_IDLE: begin
            if (en) begin
              if (WAIT_CYCLES == 1) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_BUSY;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
              end
            end
          end
          ST_BUSY: begin
            if (!en) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
              if (cnt_d == '0) state_d = ST_DONE;
            end
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_DONE);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          ready_q <= ready_d;
        end
      end

      assign rdy = ready_q;
    end
  endgenerate

  assign ready    = rdy & ~reset;
  assign addr_err = err & ~reset;
  assign rdata    = (~reset & en & ~err & ~is_store(op)) ? ldata : 32'h0;

  generate
    if (LOG_WRITES) begin : g_log
      always_ff @(posedge clk) begin
        if (we) begin
          $display("%d@%h: *%h <= %h", $time, pc, (off & ~32'd3) + BASE_ADDR, merged);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dm_subword.sv
// Self-checking bench: a byte-addressed model of two memories (no wait states
// and three wait states) checked every cycle, plus literal directed results.
module tb_dm_subword;
  import dm_pkg::*;

  localparam int DEPTH  = 3072;
  localparam int NBYTES = DEPTH * 4;
  localparam int WAITN  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        en0, en1;
  logic [2:0]  op0, op1;
  logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mb [2][NBYTES];
  int         age [2];

  always #5 clk = ~clk;

  dm_subword #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .LOG_WRITES(1'b1)) dut0 (
    .clk(clk), .reset(reset), .en(en0), .op(op0), .addr(addr0), .wdata(wdata0),
    .pc(pc0), .rdata(rdata0), .ready(ready0), .addr_err(err0)
  );

  dm_subword #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITN), .LOG_WRITES(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .op(op1), .addr(addr1), .wdata(wdata1),
    .pc(pc1), .rdata(rdata1), .ready(ready1), .addr_err(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] o);
    case (o)
      OP_LW, OP_SW:         return 4;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 1;
    endcase
  endfunction

  function automatic logic is_st(input logic [2:0] o);
    return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
  endfunction

  function automatic logic exp_err(input logic [2:0] o, input logic [31:0] a);
    int sz = acc_size(o);
    return (a >= 32'(NBYTES)) || ((a % 32'(sz)) != 0);
  endfunction

  // Loads assemble the accessed bytes directly from the byte array.
  function automatic logic [31:0] exp_load(input int k, input logic [2:0] o, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int sz = acc_size(o);
    for (int i = 0; i < sz; i++) v = v | (32'(mb[k][a + i]) << (8 * i));
    if (o == OP_LH) v = {{16{v[15]}}, v[15:0]};
    if (o == OP_LB) v = {{24{v[7]}}, v[7:0]};
    return v;
  endfunction

  task automatic step_model(input int k, input int n, input logic e, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] wd, input logic r_act,
                            input logic err_act, input logic [31:0] rd_act);
    string tag = (k == 0) ? "w0" : "w3";
    logic rdy_x, err_x;
    logic [31:0] sh;
    if (reset) begin
      check({tag, " reset ready"}, 32'(r_act), 32'h0);
      check({tag, " reset addr_err"}, 32'(err_act), 32'h0);
      check({tag, " reset rdata"}, rd_act, 32'h0);
      for (int i = 0; i < NBYTES; i++) mb[k][i] = 8'h00;
      age[k] = 0;
      return;
    end
    err_x = e && exp_err(o, a);
    rdy_x = (n == 0) ? e : (age[k] == n);
    check({tag, " ready"}, 32'(r_act), 32'(rdy_x));
    check({tag, " addr_err"}, 32'(err_act), 32'(err_x));
    if (e && !is_st(o) && (rdy_x || err_x))
      check({tag, " rdata"}, rd_act, err_x ? 32'h0 : exp_load(k, o, a));
    if (e && rdy_x && !err_x && is_st(o)) begin
      sh = wd;
      for (int i = 0; i < acc_size(o); i++) begin
        mb[k][a + i] = sh[7:0];
        sh = sh >> 8;
      end
    end
    if (n > 0) age[k] = (age[k] == n || !e) ? 0 : age[k] + 1;
  endtask

  always @(negedge clk) begin
    step_model(0, 0, en0, op0, addr0, wdata0, ready0, err0, rdata0);
    step_model(1, WAITN, en1, op1, addr1, wdata1, ready1, err1, rdata1);
  end

  task automatic drive0(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    en0 = 1'b1; op0 = o; addr0 = a; wdata0 = wd; pc0 = pc0 + 32'd4;
    @(negedge clk);
  endtask

  task automatic ld0(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] exp);
    drive0(o, a, 32'h0);
    check(name, rdata0, exp);
  endtask

  task automatic acc1(input string name, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    en1 = 1'b1; op1 = o; addr1 = a; wdata1 = wd; pc1 = pc1 + 32'd4;
    lat = -1;
    rd  = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready1) begin
        lat = c;
        rd  = rdata1;
        break;
      end
    end
    @(posedge clk); #1;
    en1 = 1'b0;
    if (lat < 0) check({name, " timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          nrdy;
    logic [31:0] rd;

    reset = 1'b1;
    en0 = 1'b1; op0 = OP_LW; addr0 = 32'h10; wdata0 = 32'h0; pc0 = 32'h0040_0000;
    en1 = 1'b0; op1 = OP_LW; addr1 = 32'h0;  wdata1 = 32'h0; pc1 = 32'h0080_0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    en0   = 1'b0;

    // Single-cycle memory: word, byte and halfword traffic.
    ld0("lw after reset", OP_LW, 32'h10, 32'h0000_0000);
    drive0(OP_SW, 32'h10, 32'h8899_AABB);
    ld0("lw 0x10", OP_LW, 32'h10, 32'h8899_AABB);
    drive0(OP_SB, 32'h12, 32'h0000_00CC);
    ld0("lb 0x12", OP_LB, 32'h12, 32'hFFFF_FFCC);
    ld0("lbu 0x12", OP_LBU, 32'h12, 32'h0000_00CC);
    ld0("lh 0x12", OP_LH, 32'h12, 32'hFFFF_88CC);
    ld0("lhu 0x10", OP_LHU, 32'h10, 32'h0000_AABB);
    drive0(OP_SH, 32'h16, 32'h1234_BEEF);
    ld0("lw 0x14", OP_LW, 32'h14, 32'hBEEF_0000);
    ld0("lh 0x16", OP_LH, 32'h16, 32'hFFFF_BEEF);

    // Address errors.
    drive0(OP_LW, 32'h13, 32'h0);
    check("lw 0x13 addr_err", 32'(err0), 32'h1);
    check("lw 0x13 rdata", rdata0, 32'h0);
    drive0(OP_SH, 32'h11, 32'h0000_1234);
    check("sh 0x11 addr_err", 32'(err0), 32'h1);
    ld0("lw 0x10 after bad sh", OP_LW, 32'h10, 32'h88CC_AABB);
    drive0(OP_SW, 32'(NBYTES), 32'hDEAD_BEEF);
    check("sw top addr_err", 32'(err0), 32'h1);

    // Last bytes of the array are in range.
    drive0(OP_SB, 32'(NBYTES - 1), 32'h0000_005A);
    check("sb last addr_err", 32'(err0), 32'h0);
    ld0("lw last word", OP_LW, 32'(NBYTES - 4), 32'h5A00_0000);
    ld0("lh last half", OP_LH, 32'(NBYTES - 2), 32'h0000_5A00);
    @(posedge clk); #1;
    en0 = 1'b0;

    // Wait-state memory: latency, back-to-back spacing, aborts.
    acc1("w3 sw", OP_SW, 32'h20, 32'hCAFE_F00D, lat, rd);
    check("w3 sw latency", 32'(lat), 32'd3);
    acc1("w3 lw", OP_LW, 32'h20, 32'h0, lat, rd);
    check("w3 lw latency", 32'(lat), 32'd3);
    check("w3 lw rdata", rd, 32'hCAFE_F00D);

    @(posedge clk); #1;
    en1 = 1'b1; op1 = OP_LW; addr1 = 32'h20;
    nrdy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready1) nrdy++;
    end
    @(posedge clk); #1;
    en1 = 1'b0;
    check("w3 back-to-back count", 32'(nrdy), 32'd2);

    @(posedge clk); #1;
    en1 = 1'b1; op1 = OP_SW; addr1 = 32'h24; wdata1 = 32'h1111_1111;
    @(posedge clk); #1;
    en1 = 1'b0;
    repeat (2) @(posedge clk);
    acc1("w3 lw aborted", OP_LW, 32'h24, 32'h0, lat, rd);
    check("w3 busy abort no write", rd, 32'h0);

    @(posedge clk); #1;
    en1 = 1'b1; op1 = OP_SW; addr1 = 32'h28; wdata1 = 32'h2222_2222;
    repeat (3) @(posedge clk);
    #1;
    en1 = 1'b0;
    @(negedge clk);
    check("w3 done ready", 32'(ready1), 32'h1);
    acc1("w3 lw dropped", OP_LW, 32'h28, 32'h0, lat, rd);
    check("w3 done drop no write", rd, 32'h0);

    // Reset in the middle of a wait-state store.
    @(posedge clk); #1;
    en1 = 1'b1; op1 = OP_SW; addr1 = 32'h2C; wdata1 = 32'h3333_3333;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset ready low", 32'(ready1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    en1   = 1'b0;
    acc1("w3 lw 0x2c", OP_LW, 32'h2C, 32'h0, lat, rd);
    check("w3 reset store dropped", rd, 32'h0);
    acc1("w3 lw 0x20", OP_LW, 32'h20, 32'h0, lat, rd);
    check("w3 cleared by reset", rd, 32'h0);
    ld0("w0 cleared by reset", OP_LW, 32'h10, 32'h0000_0000);
    @(posedge clk); #1;
    en0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
